// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
// Used by the controller, the island wrapper and the bench.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] STATE_OFF   = 2'd0;
    localparam logic [1:0] STATE_WAKE  = 2'd1;
    localparam logic [1:0] STATE_ON    = 2'd2;
    localparam logic [1:0] STATE_DRAIN = 2'd3;

    // Width of the shared wake/idle down-counter, never below one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gate_stat_cnt.sv
// Saturating statistics counter with synchronous clear.
// Clear has priority over increment.
module clk_gate_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for one gated clock island: wakes the clock ahead
// of granting service and drops it after a programmable idle timeout.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int WAKE_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 8,
    parameter int STAT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_REQ-1:0]  REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic              CLR_STATS,
    output logic              CLK_EN,
    output logic              GNT,
    output logic [1:0]        STATE,
    output logic [STAT_W-1:0] OFF_CYCLES
);

    localparam int CW = cnt_width(WAKE_CYCLES, IDLE_TIMEOUT);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_TIMEOUT - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_en_q;
    logic          clk_en_d;
    logic          gnt_q;
    logic          gnt_d;
    logic          act;

    assign act = (|REQ) | BUSY | FORCE_ON;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clk_en_d = clk_en_q;
        gnt_d    = gnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (act) begin
                    state_d  = ST_WAKE;
                    cnt_d    = WAKE_LOAD;
                    clk_en_d = 1'b1;
                end
            end
            // A wake is never aborted, bounding the CLK_EN toggle rate.
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ON;
                    gnt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_ON: begin
                if (!act) begin
                    state_d = ST_DRAIN;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ST_DRAIN: begin
                if (act) begin
                    state_d = ST_ON;
                end else if (cnt_q == '0) begin
                    state_d  = ST_OFF;
                    clk_en_d = 1'b0;
                    gnt_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d  = ST_OFF;
                clk_en_d = 1'b0;
                gnt_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
            gnt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            gnt_q    <= gnt_d;
        end
    end

    clk_gate_stat_cnt #(
        .W(STAT_W)
    ) u_stat (
        .clk  (CLK),
        .rst  (RST),
        .clr  (CLR_STATS),
        .inc  (state_q == ST_OFF),
        .count(OFF_CYCLES)
    );

    assign CLK_EN = clk_en_q;
    assign GNT    = gnt_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl; a second instance with a 4-bit
// statistics counter exercises saturation.
module tb_clk_gate_ctrl;
    import clk_gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        busy;
    logic        force_on;
    logic        clr_stats;
    logic        clk_en;
    logic        gnt;
    logic [1:0]  state;
    logic [15:0] off_cycles;
    logic        clk_en4;
    logic        gnt4;
    logic [1:0]  state4;
    logic [3:0]  off_cycles4;

    int n_chk  = 0;
    int n_fail = 0;

    // {STATE, CLK_EN, GNT}
    localparam logic [3:0] V_OFF   = 4'b0000;
    localparam logic [3:0] V_WAKE  = 4'b0110;
    localparam logic [3:0] V_ON    = 4'b1011;
    localparam logic [3:0] V_DRAIN = 4'b1111;

    always #5 clk = ~clk;

    clk_gate_ctrl dut (
        .CLK(clk), .RST(rst), .REQ(req), .BUSY(busy),
        .FORCE_ON(force_on), .CLR_STATS(clr_stats),
        .CLK_EN(clk_en), .GNT(gnt), .STATE(state),
        .OFF_CYCLES(off_cycles)
    );

    clk_gate_ctrl #(.STAT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .REQ(req), .BUSY(busy),
        .FORCE_ON(force_on), .CLR_STATS(clr_stats),
        .CLK_EN(clk_en4), .GNT(gnt4), .STATE(state4),
        .OFF_CYCLES(off_cycles4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {state, clk_en, gnt};
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = '0; busy = 1'b0;
        force_on = 1'b0; clr_stats = 1'b0;
        step(); step();
        n_chk++;
        if (obs() !== V_OFF || off_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: st/en/gnt=%b off=%0d want %b off=0",
                     obs(), off_cycles, V_OFF);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_chk++;
        if (obs() !== V_OFF || off_cycles !== 16'd20) begin
            n_fail++;
            $display("FAIL idle: st/en/gnt=%b off=%0d want %b off=20",
                     obs(), off_cycles, V_OFF);
        end
        n_chk++;
        if (off_cycles4 !== 4'd15) begin
            n_fail++;
            $display("FAIL stat_sat: got %0d want 15", off_cycles4);
        end
    endtask

    task automatic test_wake();
        req = 4'b0010;
        step();
        n_chk++;
        if (obs() !== V_WAKE) begin
            n_fail++;
            $display("FAIL wake_e0: got %b want %b", obs(), V_WAKE);
        end
        step();
        n_chk++;
        if (obs() !== V_WAKE) begin
            n_fail++;
            $display("FAIL wake_e1: got %b want %b", obs(), V_WAKE);
        end
        step();
        n_chk++;
        if (obs() !== V_ON) begin
            n_fail++;
            $display("FAIL wake_e2: got %b want %b", obs(), V_ON);
        end
        n_chk++;
        if (off_cycles !== 16'd21) begin
            n_fail++;
            $display("FAIL off_after_wake: got %0d want 21", off_cycles);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) step();
        n_chk++;
        if (obs() !== V_ON) begin
            n_fail++;
            $display("FAIL hold_on: got %b want %b", obs(), V_ON);
        end
        req = '0;
        step();
        n_chk++;
        if (obs() !== V_DRAIN) begin
            n_fail++;
            $display("FAIL drain_k: got %b want %b", obs(), V_DRAIN);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            n_chk++;
            if (obs() !== V_DRAIN) begin
                n_fail++;
                $display("FAIL drain_k%0d: got %b want %b",
                         i, obs(), V_DRAIN);
            end
        end
        step();
        n_chk++;
        if (obs() !== V_OFF) begin
            n_fail++;
            $display("FAIL timeout_off: got %b want %b", obs(), V_OFF);
        end
    endtask

    task automatic test_redrain();
        logic dropped;
        req = 4'b0001;
        step(); step(); step();
        req = '0;
        step();
        dropped = 1'b0;
        for (int i = 1; i < 7; i++) begin
            step();
            if (!clk_en || !gnt) dropped = 1'b1;
        end
        req = 4'b0001;
        step();
        n_chk++;
        if (obs() !== V_ON || dropped) begin
            n_fail++;
            $display("FAIL redrain: got %b drop=%b want %b drop=0",
                     obs(), dropped, V_ON);
        end
        req = '0;
        step();
        for (int i = 1; i < 8; i++) step();
        req = 4'b1000;
        step();
        n_chk++;
        if (obs() !== V_ON) begin
            n_fail++;
            $display("FAIL act_at_cnt0: got %b want %b", obs(), V_ON);
        end
    endtask

    task automatic test_busy_force();
        logic left_on;
        req = '0; busy = 1'b1;
        left_on = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (obs() !== V_ON) left_on = 1'b1;
        end
        n_chk++;
        if (left_on) begin
            n_fail++;
            $display("FAIL busy_hold: left ON got %b want %b",
                     obs(), V_ON);
        end
        busy = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_chk++;
        if (obs() !== V_OFF) begin
            n_fail++;
            $display("FAIL busy_release: got %b want %b", obs(), V_OFF);
        end
        force_on = 1'b1;
        step();
        n_chk++;
        if (obs() !== V_WAKE) begin
            n_fail++;
            $display("FAIL force_wake: got %b want %b", obs(), V_WAKE);
        end
        step(); step();
        n_chk++;
        if (obs() !== V_ON) begin
            n_fail++;
            $display("FAIL force_on: got %b want %b", obs(), V_ON);
        end
        force_on = 1'b0;
        for (int i = 0; i < 9; i++) step();
        req = 4'b0100;
        step();
        req = '0;
        n_chk++;
        if (obs() !== V_WAKE) begin
            n_fail++;
            $display("FAIL pulse_wake: got %b want %b", obs(), V_WAKE);
        end
        step(); step();
        n_chk++;
        if (obs() !== V_ON) begin
            n_fail++;
            $display("FAIL pulse_on: got %b want %b", obs(), V_ON);
        end
        step();
        n_chk++;
        if (obs() !== V_DRAIN) begin
            n_fail++;
            $display("FAIL pulse_drain: got %b want %b", obs(), V_DRAIN);
        end
        for (int i = 0; i < 8; i++) step();
        n_chk++;
        if (obs() !== V_OFF) begin
            n_fail++;
            $display("FAIL pulse_off: got %b want %b", obs(), V_OFF);
        end
    endtask

    task automatic test_reset_drain();
        req = 4'b0001;
        step(); step(); step();
        req = '0;
        step();
        for (int i = 0; i < 4; i++) step();
        n_chk++;
        if (obs() !== V_DRAIN) begin
            n_fail++;
            $display("FAIL pre_rst_drain: got %b want %b", obs(), V_DRAIN);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if (obs() !== V_OFF || off_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_drain: got %b off=%0d want %b off=0",
                     obs(), off_cycles, V_OFF);
        end
    endtask

    task automatic test_stats();
        step(); step(); step();
        n_chk++;
        if (off_cycles !== 16'd3 || off_cycles4 !== 4'd3) begin
            n_fail++;
            $display("FAIL stat_cnt: got %0d/%0d want 3/3",
                     off_cycles, off_cycles4);
        end
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        n_chk++;
        if (off_cycles !== 16'd0 || off_cycles4 !== 4'd0) begin
            n_fail++;
            $display("FAIL stat_clr: got %0d/%0d want 0/0",
                     off_cycles, off_cycles4);
        end
        for (int i = 0; i < 21; i++) step();
        n_chk++;
        if (off_cycles !== 16'd21 || off_cycles4 !== 4'd15) begin
            n_fail++;
            $display("FAIL stat_sat2: got %0d/%0d want 21/15",
                     off_cycles, off_cycles4);
        end
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        n_chk++;
        if (off_cycles !== 16'd0 || off_cycles4 !== 4'd0) begin
            n_fail++;
            $display("FAIL stat_clr_sat: got %0d/%0d want 0/0",
                     off_cycles, off_cycles4);
        end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_timeout();
        test_redrain();
        test_busy_force();
        test_reset_drain();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
